// File: rtl/tpg_pkg.sv
// Shared types for the multi-pattern test pattern generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tpg_pkg;

  // Pattern selector; the encoding matches the mode input pins.
  typedef enum logic [1:0] {
    TPG_RAMP  = 2'd0,
    TPG_BARS  = 2'd1,
    TPG_CHECK = 2'd2,
    TPG_SOLID = 2'd3
  } tpgMode_e;

  // Colour-bar indices in left-to-right display order.
  localparam logic [2:0] BAR_BLACK   = 3'd0;
  localparam logic [2:0] BAR_BLUE    = 3'd1;
  localparam logic [2:0] BAR_GREEN   = 3'd2;
  localparam logic [2:0] BAR_CYAN    = 3'd3;
  localparam logic [2:0] BAR_RED     = 3'd4;
  localparam logic [2:0] BAR_MAGENTA = 3'd5;
  localparam logic [2:0] BAR_YELLOW  = 3'd6;
  localparam logic [2:0] BAR_WHITE   = 3'd7;

  // Map a bar index to its {R,G,B} on/off mask.
  function automatic logic [2:0] barMask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      BAR_BLACK:   m = 3'b000;
      BAR_BLUE:    m = 3'b001;
      BAR_GREEN:   m = 3'b010;
      BAR_CYAN:    m = 3'b011;
      BAR_RED:     m = 3'b100;
      BAR_MAGENTA: m = 3'b101;
      BAR_YELLOW:  m = 3'b110;
      BAR_WHITE:   m = 3'b111;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tpg_timing.sv
// Raster counters plus sync / active / marker decode against live timing inputs.
// Latency: decode outputs are combinational from the registered x/y counters.
// Backpressure: counters advance only when en is high, otherwise they hold.
module tpg_timing
  import tpg_pkg::*;
#(
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [H_BITS-1:0] tHS_START,
  input  logic [H_BITS-1:0] tHS_END,
  input  logic [H_BITS-1:0] tHACT_START,
  input  logic [H_BITS-1:0] tHACT_END,
  input  logic [H_BITS-1:0] tH_END,
  input  logic [V_BITS-1:0] tVS_START,
  input  logic [V_BITS-1:0] tVS_END,
  input  logic [V_BITS-1:0] tVACT_START,
  input  logic [V_BITS-1:0] tVACT_END,
  input  logic [V_BITS-1:0] tV_END,
  output logic [H_BITS-1:0] x,
  output logic [V_BITS-1:0] y,
  output logic              hs,
  output logic              vs,
  output logic              hact,
  output logic              vact,
  output logic              sof,
  output logic              eol
);

  // Step the raster; >= on the end compare makes a shrunken period wrap at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x >= tH_END) begin
        x <= '0;
        if (y >= tV_END) y <= '0;
        else             y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Half-open window decode; start >= end simply never asserts.
  assign hs   = (x >= tHS_START)   && (x < tHS_END);
  assign vs   = (y >= tVS_START)   && (y < tVS_END);
  assign hact = (x >= tHACT_START) && (x < tHACT_END);
  assign vact = (y >= tVACT_START) && (y < tVACT_END);
  assign sof  = hact && vact && (x == tHACT_START) && (y == tVACT_START);
  assign eol  = hact && vact && (x == tHACT_END - 1'b1);

endmodule

// File: rtl/tpg_multi.sv
// Programmable-raster test pattern generator (ramp/bars/checker/solid); TPG_MOTION_EN adds frame scrolling.
// Latency: every output is registered one clk after the raster position it describes.
// Backpressure: en low freezes the raster and holds every output, including vld_q.
module tpg_multi
  import tpg_pkg::*;
#(
  parameter int PW        = 8,
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int BAR_SHIFT = 7,
  parameter int CHK_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [3*PW-1:0]   solid_rgb,
  input  logic [H_BITS-1:0] tHS_START,
  input  logic [H_BITS-1:0] tHS_END,
  input  logic [H_BITS-1:0] tHACT_START,
  input  logic [H_BITS-1:0] tHACT_END,
  input  logic [H_BITS-1:0] tH_END,
  input  logic [V_BITS-1:0] tVS_START,
  input  logic [V_BITS-1:0] tVS_END,
  input  logic [V_BITS-1:0] tVACT_START,
  input  logic [V_BITS-1:0] tVACT_END,
  input  logic [V_BITS-1:0] tV_END,
  output logic              hs_q,
  output logic              vs_q,
  output logic              vld_q,
  output logic              sof_q,
  output logic              eol_q,
`ifdef TPG_MOTION_EN
  output logic [7:0]        frame_cnt_q,
`endif
  output logic [3*PW-1:0]   rgb
);

  logic [H_BITS-1:0] x, xa, xp;
  logic [V_BITS-1:0] y, ya;
  logic              hs, vs, hact, vact, sof, eol;
  logic              frameStart;
  tpgMode_e          modeR, curMode;
  logic [2:0]        barIdx, barRgb;
  logic              chk;
  logic [3*PW-1:0]   pix;

  tpg_timing #(
    .H_BITS(H_BITS),
    .V_BITS(V_BITS)
  ) uTiming (
    .clk(clk), .rst(rst), .en(en),
    .tHS_START(tHS_START), .tHS_END(tHS_END),
    .tHACT_START(tHACT_START), .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END),
    .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
    .x(x), .y(y),
    .hs(hs), .vs(vs), .hact(hact), .vact(vact), .sof(sof), .eol(eol)
  );

  assign frameStart = (x == '0) && (y == '0);

  // The frame-start pixel already uses the freshly sampled mode so a frame is never mixed.
  assign curMode = frameStart ? tpgMode_e'(mode) : modeR;

  // Latch the pattern select once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    modeR <= TPG_RAMP;
    else if (en && frameStart)  modeR <= tpgMode_e'(mode);
  end

`ifdef TPG_MOTION_EN
  logic [7:0] frameCnt, frameOff, curOff;

  // Count frame starts; the running frame scrolls by the count seen at its own start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCnt <= '0;
      frameOff <= '0;
    end else if (en && frameStart) begin
      frameCnt <= frameCnt + 8'd1;
      frameOff <= frameCnt;
    end
  end

  assign curOff = frameStart ? frameCnt : frameOff;
`endif

  // Pattern evaluation at the current raster position; black outside the active window.
  always_comb begin
    xa = x - tHACT_START;
    ya = y - tVACT_START;
`ifdef TPG_MOTION_EN
    xp = xa + H_BITS'(curOff);
`else
    xp = xa;
`endif
    barIdx = 3'(xp >> BAR_SHIFT);
    barRgb = barMask(barIdx);
    chk    = 1'(xp >> CHK_SHIFT) ^ 1'(ya >> CHK_SHIFT);
    pix    = '0;
    if (hact && vact) begin
      case (curMode)
        TPG_RAMP:  pix = {PW'(xp), PW'(ya), PW'(xp) + PW'(ya)};
        TPG_BARS:  pix = {{PW{barRgb[2]}}, {PW{barRgb[1]}}, {PW{barRgb[0]}}};
        TPG_CHECK: pix = {(3*PW){chk}};
        TPG_SOLID: pix = solid_rgb;
        default:   pix = '0;
      endcase
    end
  end

  // Output registers, advanced only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      vld_q       <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      rgb         <= '0;
`ifdef TPG_MOTION_EN
      frame_cnt_q <= '0;
`endif
    end else if (en) begin
      hs_q        <= hs;
      vs_q        <= vs;
      vld_q       <= hact && vact;
      sof_q       <= sof;
      eol_q       <= eol;
      rgb         <= pix;
`ifdef TPG_MOTION_EN
      frame_cnt_q <= curOff;
`endif
    end
  end

endmodule

// File: tb/tb_tpg_multi.sv
// Self-checking bench for tpg_multi against a raster-index reference model.
// Latency: n/a.
// Backpressure: exercises en pacing (toggling and random).
module tb_tpg_multi;

  localparam int PW = 8;
  localparam int HB = 12;
  localparam int VB = 12;
  localparam int BS = 0;
  localparam int CS = 1;
`ifdef TPG_MOTION_EN
  localparam bit MOTION = 1'b1;
`else
  localparam bit MOTION = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [23:0] solid = 24'h0;
  logic [HB-1:0] tHS_START = 12'd0, tHS_END = 12'd2, tHACT_START = 12'd4, tHACT_END = 12'd16, tH_END = 12'd19;
  logic [VB-1:0] tVS_START = 12'd0, tVS_END = 12'd1, tVACT_START = 12'd2, tVACT_END = 12'd8, tV_END = 12'd9;
  logic hs_q, vs_q, vld_q, sof_q, eol_q;
  logic [23:0] rgb;
  logic [7:0] frame_cnt_q;
  logic [28:0] obs;

  int tests = 0;
  int fails = 0;

  // reference model state: enabled cycles since reset, latched mode, frames started
  int mN = 0;
  int mMode = 0;
  int mFrames = 0;
  int mOff = 0;
  logic [28:0] mLast = '0;
  logic [23:0] refSeq[$];
  logic [23:0] barSeq [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                              24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

  tpg_multi #(.PW(PW), .H_BITS(HB), .V_BITS(VB), .BAR_SHIFT(BS), .CHK_SHIFT(CS)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
    .tVACT_END(tVACT_END), .tV_END(tV_END),
    .hs_q(hs_q), .vs_q(vs_q), .vld_q(vld_q), .sof_q(sof_q), .eol_q(eol_q),
`ifdef TPG_MOTION_EN
    .frame_cnt_q(frame_cnt_q),
`endif
    .rgb(rgb)
  );

`ifndef TPG_MOTION_EN
  assign frame_cnt_q = 8'd0;
`endif

  assign obs = {hs_q, vs_q, vld_q, sof_q, eol_q, rgb};

  always #5 clk = ~clk;

  function automatic logic [28:0] refOut(int x, int y, int m, int off);
    int hS, hE, haS, haE, vS, vE, vaS, vaE, xa, ya, idx;
    logic hsv, vsv, hav, vav, vldv, sofv, eolv;
    logic [23:0] pix;
    hS = int'(tHS_START); hE = int'(tHS_END); haS = int'(tHACT_START); haE = int'(tHACT_END);
    vS = int'(tVS_START); vE = int'(tVS_END); vaS = int'(tVACT_START); vaE = int'(tVACT_END);
    hsv  = (x >= hS) && (x < hE);
    vsv  = (y >= vS) && (y < vE);
    hav  = (x >= haS) && (x < haE);
    vav  = (y >= vaS) && (y < vaE);
    vldv = hav && vav;
    sofv = vldv && (x == haS) && (y == vaS);
    eolv = vldv && (x == haE - 1);
    pix  = 24'h0;
    if (vldv) begin
      xa = (x - haS + off) & 32'hFFF;
      ya = (y - vaS) & 32'hFFF;
      case (m)
        0: pix = {8'(xa), 8'(ya), 8'(xa + ya)};
        1: begin
          idx = (xa >> BS) & 7;
          pix = {((idx & 4) != 0) ? 8'hFF : 8'h00, ((idx & 2) != 0) ? 8'hFF : 8'h00,
                 ((idx & 1) != 0) ? 8'hFF : 8'h00};
        end
        2: pix = ((((xa >> CS) ^ (ya >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: pix = solid;
      endcase
    end
    return {hsv, vsv, vldv, sofv, eolv, pix};
  endfunction

  // drive one clock with the given en and return the model's expected outputs
  task automatic tick(input logic e, output logic [28:0] exp);
    int x, y;
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      x = mN % (int'(tH_END) + 1);
      y = (mN / (int'(tH_END) + 1)) % (int'(tV_END) + 1);
      if (x == 0 && y == 0) begin
        mMode = int'(mode);
        mOff = mFrames % 256;
        mFrames++;
      end
      mLast = refOut(x, y, mMode, MOTION ? mOff : 0);
      mN++;
    end
    exp = mLast;
  endtask

  task automatic doReset();
    en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mN = 0; mFrames = 0; mOff = 0; mLast = '0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests++;
    if (obs !== 29'h0 || frame_cnt_q !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: got %h/%h want 0", obs, frame_cnt_q);
    end
    rst = 1'b0;
    mN = 0; mFrames = 0; mOff = 0; mLast = '0;
  endtask

  task automatic test_ramp();
    logic [28:0] exp;
    int vldCnt, eolCnt, sofCnt, hsCnt, eol0, eol1;
    logic [23:0] firstRgb, eolRgb;
    vldCnt = 0; eolCnt = 0; sofCnt = 0; hsCnt = 0; eol0 = -1; eol1 = -1;
    firstRgb = 24'hDEAD00; eolRgb = 24'hDEAD00;
    mode = 2'd0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL ramp cyc %0d: got %h want %h", i, obs, exp);
      end
      if (vld_q) begin
        if (vldCnt == 0) firstRgb = rgb;
        vldCnt++;
        refSeq.push_back(rgb);
      end
      if (eol_q) begin
        if (eolCnt == 0) begin eol0 = i; eolRgb = rgb; end
        if (eolCnt == 1) eol1 = i;
        eolCnt++;
      end
      if (sof_q) sofCnt++;
      if (hs_q) hsCnt++;
    end
    tests += 7;
    if (vldCnt != 72) begin fails++; $display("FAIL ramp_vld_count: got %0d want 72", vldCnt); end
    if (eolCnt != 6) begin fails++; $display("FAIL ramp_lines: got %0d want 6", eolCnt); end
    if (sofCnt != 1) begin fails++; $display("FAIL ramp_sof_count: got %0d want 1", sofCnt); end
    if (hsCnt != 20) begin fails++; $display("FAIL ramp_hs_count: got %0d want 20", hsCnt); end
    if (firstRgb !== 24'h000000) begin fails++; $display("FAIL ramp_first_rgb: got %h want 000000", firstRgb); end
    if (eolRgb !== 24'h0B000B) begin fails++; $display("FAIL ramp_eol_rgb: got %h want 0b000b", eolRgb); end
    if (eol1 - eol0 != 20) begin fails++; $display("FAIL ramp_line_period: got %0d want 20", eol1 - eol0); end
  endtask

  task automatic test_bars();
    logic [28:0] exp;
    int k;
    k = 0;
    mode = 2'd1;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) mode = 2'd2;
      tick(1'b1, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL bars cyc %0d: got %h want %h", i, obs, exp);
      end
      if (vld_q && k < 12) begin
        tests++;
        if (rgb !== barSeq[k % 8]) begin
          fails++;
          $display("FAIL bars_seq px %0d: got %h want %h", k, rgb, barSeq[k % 8]);
        end
        k++;
      end
    end
    tests++;
    if (k != 12) begin fails++; $display("FAIL bars_px_count: got %0d want 12", k); end
  endtask

  task automatic test_checker_solid();
    logic [28:0] exp;
    int k;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL checker cyc %0d: got %h want %h", i, obs, exp);
      end
      if (vld_q) begin
        if (k == 0 || k == 2) begin
          tests++;
          if (rgb !== ((k == 2) ? 24'hFFFFFF : 24'h000000)) begin
            fails++;
            $display("FAIL checker_px %0d: got %h", k, rgb);
          end
        end
        k++;
      end
    end
    mode = 2'd3;
    solid = 24'h123456;
    for (int i = 0; i < 400; i++) begin
      if (i >= 200 && i % 25 == 0) solid = 24'($urandom);
      tick(1'b1, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL solid cyc %0d: got %h want %h", i, obs, exp);
      end
      if (i < 200) begin
        tests++;
        if (vld_q && rgb !== 24'h123456) begin
          fails++;
          $display("FAIL solid_px cyc %0d: got %h want 123456", i, rgb);
        end else if (!vld_q && rgb !== 24'h0) begin
          fails++;
          $display("FAIL solid_blank cyc %0d: got %h want 0", i, rgb);
        end
      end
    end
  endtask

  task automatic test_en_pacing();
    logic [28:0] exp, prev;
    logic [23:0] seq[$];
    doReset();
    mode = 2'd0;
    prev = obs;
    for (int i = 0; i < 400; i++) begin
      tick((i % 2) == 0, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL pacing cyc %0d: got %h want %h", i, obs, exp);
      end
      if (i % 2 == 1) begin
        tests++;
        if (obs !== prev) begin
          fails++;
          $display("FAIL pacing_hold cyc %0d: got %h want %h", i, obs, prev);
        end
      end else if (vld_q) begin
        seq.push_back(rgb);
      end
      prev = obs;
    end
    tests++;
    if (seq.size() != refSeq.size()) begin
      fails++;
      $display("FAIL pacing_len: got %0d want %0d", seq.size(), refSeq.size());
    end else begin
      foreach (seq[j]) begin
        tests++;
        if (seq[j] !== refSeq[j]) begin
          fails++;
          $display("FAIL pacing_seq %0d: got %h want %h", j, seq[j], refSeq[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [28:0] exp;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) mode = 2'($urandom_range(0, 3));
      if (i % 25 == 0) solid = 24'($urandom);
      tick($urandom_range(0, 3) != 0, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_boundary();
    logic [28:0] exp;
    doReset();
    mode = 2'd0;
    for (int i = 0; i < 12; i++) tick(1'b1, exp);
    tH_END = 12'd5;
    tick(1'b1, exp);
    tests++;
    if ({hs_q, vs_q, vld_q} !== 3'b010) begin
      fails++;
      $display("FAIL boundary_x12: got %b want 010", {hs_q, vs_q, vld_q});
    end
    tick(1'b1, exp);
    tests++;
    if ({hs_q, vs_q, vld_q} !== 3'b100) begin
      fails++;
      $display("FAIL boundary_wrap: got %b want 100", {hs_q, vs_q, vld_q});
    end
    for (int i = 0; i < 6; i++) tick(1'b1, exp);
    tests++;
    if ({hs_q, vs_q} !== 2'b10) begin
      fails++;
      $display("FAIL boundary_short_line: got %b want 10", {hs_q, vs_q});
    end
    tH_END = 12'd19;
  endtask

  task automatic test_reset_mid();
    logic [28:0] exp;
    doReset();
    mode = 2'd3;
    solid = 24'hABCDEF;
    for (int i = 0; i < 95; i++) begin
      tick(1'b1, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL midrst_pre cyc %0d: got %h want %h", i, obs, exp);
      end
    end
    tests++;
    if (vld_q !== 1'b1) begin fails++; $display("FAIL midrst_active: got %b want 1", vld_q); end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== 29'h0) begin fails++; $display("FAIL midrst_async: got %h want 0", obs); end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== 29'h0) begin fails++; $display("FAIL midrst_clk: got %h want 0", obs); end
    rst = 1'b0;
    mN = 0; mFrames = 0; mOff = 0; mLast = '0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, exp);
      if (i == 0) begin
        tests++;
        if (obs !== {2'b11, 27'h0}) begin
          fails++;
          $display("FAIL midrst_restart: got %h want %h", obs, {2'b11, 27'h0});
        end
      end
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL midrst_post cyc %0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

`ifdef TPG_MOTION_EN
  task automatic test_motion();
    logic [28:0] exp;
    int k;
    k = 0;
    doReset();
    mode = 2'd0;
    for (int i = 0; i < 600; i++) begin
      tick(1'b1, exp);
      tests++;
      if (obs !== exp || frame_cnt_q !== 8'(mOff)) begin
        fails++;
        $display("FAIL motion cyc %0d: got %h/%h want %h/%h", i, obs, frame_cnt_q, exp, 8'(mOff));
      end
      if (sof_q) begin
        tests++;
        if (frame_cnt_q !== 8'(k) || rgb[23:16] !== 8'(k)) begin
          fails++;
          $display("FAIL motion_sof %0d: got cnt %0d r %0d want %0d", k, frame_cnt_q, rgb[23:16], k);
        end
        k++;
      end
    end
    tests++;
    if (k != 3) begin fails++; $display("FAIL motion_frames: got %0d want 3", k); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_bars();
    test_checker_solid();
    test_en_pacing();
    test_random();
    test_boundary();
    test_reset_mid();
`ifdef TPG_MOTION_EN
    test_motion();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
